freq_readout_scanner: RTL

Parametrised multi-channel pixel-frequency measurement and readout engine for the fast-readout pixel array. Each of NUM_CH synchronous pixel frequency outputs gets its own period, high-time and low-time counters. On command, the block serialises the latched results channel by channel onto a byte-wide valid/ready stream that feeds the chip output pins. It provides the readout path that the single-fixed-width counter bank lacks.

---
 rtl/freq_readout_scanner.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/freq_readout_scanner.sv
// freq_readout_scanner: per-channel period/high/low measurement plus a byte-serial readout scan.
// Ports: clk, rst_n (synchronous, active-low); freq_in per-channel inputs already in the clk domain;
//   start/mode/ch_mask scan command; out_data/out_valid/out_ready/out_last byte stream; busy; done pulse.
// Latency: header byte valid 2 cycles after start; backpressure stalls the stream with data/last held stable.
module freq_readout_scanner #(
  parameter int NUM_CH       = 16,
  parameter int COUNTER_BITS = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] freq_in,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [NUM_CH-1:0] ch_mask,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done
);
  localparam int CB   = COUNTER_BITS;
  localparam int BPW  = CB / 8;
  localparam int BUFW = 3 * CB;
  localparam int IDXW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CB-1:0] MAX = {CB{1'b1}};

  typedef enum logic [1:0] {IDLE, LOAD, HDR, DATA} state_t;

  function automatic logic [CB-1:0] sat_inc(input logic [CB-1:0] v);
    return (v == MAX) ? v : v + CB'(1);
  endfunction

  // ---------------- measurement ----------------
  logic [NUM_CH-1:0] in_d, rise, fall, armed, new_flag, sat_flag, stuck_seen, clr_new;
  logic [CB-1:0]     pcnt [NUM_CH];
  logic [CB-1:0]     hcnt [NUM_CH];
  logic [CB-1:0]     lcnt [NUM_CH];
  logic [CB-1:0]     per_q [NUM_CH];
  logic [CB-1:0]     high_q [NUM_CH];
  logic [CB-1:0]     low_q [NUM_CH];

  assign rise = freq_in & ~in_d;
  assign fall = ~freq_in & in_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_d       <= '0;
      armed      <= '0;
      new_flag   <= '0;
      sat_flag   <= '0;
      stuck_seen <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        pcnt[i]   <= '0;
        hcnt[i]   <= '0;
        lcnt[i]   <= '0;
        per_q[i]  <= '0;
        high_q[i] <= '0;
        low_q[i]  <= '0;
      end
    end else begin
      in_d <= freq_in;
      for (int i = 0; i < NUM_CH; i++) begin
        pcnt[i] <= rise[i] ? CB'(1) : sat_inc(pcnt[i]);
        if (rise[i])         hcnt[i] <= CB'(1);
        else if (freq_in[i]) hcnt[i] <= sat_inc(hcnt[i]);
        if (fall[i])          lcnt[i] <= CB'(1);
        else if (!freq_in[i]) lcnt[i] <= sat_inc(lcnt[i]);

        if (rise[i]) armed[i] <= 1'b1;

        // A latch in the same cycle as the scan snapshot keeps new_flag set.
        if (armed[i] && rise[i]) begin
          per_q[i]      <= pcnt[i];
          low_q[i]      <= lcnt[i];
          new_flag[i]   <= 1'b1;
          sat_flag[i]   <= (pcnt[i] == MAX);
          stuck_seen[i] <= 1'b0;
        end else begin
          if (clr_new[i]) new_flag[i] <= 1'b0;
          // Stuck input: report saturation once per missing edge, silently.
          if (armed[i] && (pcnt[i] == MAX) && !stuck_seen[i]) begin
            per_q[i]      <= MAX;
            sat_flag[i]   <= 1'b1;
            stuck_seen[i] <= 1'b1;
          end
        end

        if (armed[i] && fall[i]) high_q[i] <= hcnt[i];
      end
    end
  end

  // ---------------- scan ----------------
  state_t            state, state_nx;
  logic [1:0]        mode_q;
  logic [NUM_CH-1:0] rem_q;     // enabled channels not yet sent
  logic [7:0]        hdr_q;
  logic [BUFW-1:0]   buf_q;     // words left-aligned, shifted out MSB byte first
  logic [3:0]        bcnt_q;    // data bytes remaining minus one
  logic              done_q, done_nx;
  logic              found;
  logic [IDXW-1:0]   idx;

  // Lowest remaining enabled channel.
  always_comb begin
    found = |rem_q;
    idx   = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (rem_q[i]) idx = IDXW'(i);
    end
  end

  assign clr_new = (state == LOAD && found) ? (NUM_CH'(1) << idx) : '0;
  assign done    = done_q;

  always_comb begin
    state_nx  = state;
    done_nx   = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE: if (start) state_nx = LOAD;
      LOAD: begin
        if (found) begin
          state_nx = HDR;
        end else begin
          state_nx = IDLE;
          done_nx  = 1'b1;
        end
      end
      HDR: begin
        out_valid = 1'b1;
        out_data  = hdr_q;
        if (out_ready) state_nx = DATA;
      end
      DATA: begin
        out_valid = 1'b1;
        out_data  = buf_q[BUFW-1 -: 8];
        out_last  = (bcnt_q == 4'd0) && (rem_q == '0);
        if (out_ready && bcnt_q == 4'd0) begin
          if (rem_q != '0) begin
            state_nx = LOAD;
          end else begin
            state_nx = IDLE;
            done_nx  = 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      done_q <= 1'b0;
      mode_q <= '0;
      rem_q  <= '0;
      hdr_q  <= '0;
      buf_q  <= '0;
      bcnt_q <= '0;
    end else begin
      state  <= state_nx;
      done_q <= done_nx;
      case (state)
        IDLE: begin
          if (start) begin
            mode_q <= mode;
            rem_q  <= ch_mask;
          end
        end
        LOAD: begin
          if (found) begin
            rem_q <= rem_q & ~clr_new;
            hdr_q <= {new_flag[idx], sat_flag[idx], 6'(idx)};
            case (mode_q)
              2'b00:   buf_q <= {per_q[idx], {(2*CB){1'b0}}};
              2'b01:   buf_q <= {high_q[idx], {(2*CB){1'b0}}};
              2'b10:   buf_q <= {low_q[idx], {(2*CB){1'b0}}};
              default: buf_q <= {per_q[idx], high_q[idx], low_q[idx]};
            endcase
            bcnt_q <= (mode_q == 2'b11) ? 4'(3*BPW-1) : 4'(BPW-1);
          end
        end
        DATA: begin
          if (out_ready) begin
            buf_q  <= buf_q << 8;
            bcnt_q <= bcnt_q - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
